// File: rtl/csa45_accumulator.sv
// Streaming accumulator built on a 45-bit carry-select adder: sums num_terms operands
// from a valid/ready input and presents the total plus a sticky overflow on a valid/ready output.

module csa45_rca #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o
);

    logic c;

    always_comb begin
        c   = cin_i;
        s_o = '0;
        for (int i = 0; i < W; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

module C_Sel_A_45bit (
    input  logic [45:1] A,
    input  logic [45:1] B,
    input  logic        cin,
    output logic [45:1] S,
    output logic        cout
);

    localparam int BLK  = 9;
    localparam int NBLK = 5;

    logic [44:0]     a;
    logic [44:0]     b;
    logic [44:0]     sum;
    logic [BLK-1:0]  blk0Sum;
    logic            blk0Cout;
    logic [BLK-1:0]  selSum0 [1:NBLK-1];
    logic [BLK-1:0]  selSum1 [1:NBLK-1];
    logic [NBLK-1:1] selC0;
    logic [NBLK-1:1] selC1;
    logic            c;

    assign a = A;
    assign b = B;

    csa45_rca #(.W(BLK)) u_blk0 (
        .a_i    (a[BLK-1:0]),
        .b_i    (b[BLK-1:0]),
        .cin_i  (cin),
        .s_o    (blk0Sum),
        .cout_o (blk0Cout)
    );

    // Upper blocks precompute both carry-in outcomes so only a mux sits on the carry path.
    genvar k;
    generate
        for (k = 1; k < NBLK; k++) begin : g_sel
            csa45_rca #(.W(BLK)) u_c0 (
                .a_i    (a[k*BLK +: BLK]),
                .b_i    (b[k*BLK +: BLK]),
                .cin_i  (1'b0),
                .s_o    (selSum0[k]),
                .cout_o (selC0[k])
            );
            csa45_rca #(.W(BLK)) u_c1 (
                .a_i    (a[k*BLK +: BLK]),
                .b_i    (b[k*BLK +: BLK]),
                .cin_i  (1'b1),
                .s_o    (selSum1[k]),
                .cout_o (selC1[k])
            );
        end
    endgenerate

    always_comb begin
        sum            = '0;
        sum[BLK-1:0]   = blk0Sum;
        c              = blk0Cout;
        for (int j = 1; j < NBLK; j++) begin
            sum[j*BLK +: BLK] = c ? selSum1[j] : selSum0[j];
            c                 = c ? selC1[j] : selC0[j];
        end
        cout = c;
    end

    assign S = sum;

endmodule

module csa45_accumulator #(
    parameter int WIDTH = 45,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:1]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:1]   S_out,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:1]   acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH:1]   addSum;
    logic             addCout;

    C_Sel_A_45bit u_adder (
        .A    (acc_q),
        .B    (in_data),
        .cin  (1'b0),
        .S    (addSum),
        .cout (addCout)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = num_terms;
                    state_d = (num_terms != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = addSum;
                    ovf_d = ovf_q | addCout;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A start arriving with the handshake is deliberately dropped.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign S_out     = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa45_accumulator.sv
// Directed self-checking bench for csa45_accumulator with hand-computed expected values.

module tb_csa45_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  num_terms;
    logic        in_valid;
    logic        in_ready;
    logic [45:1] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [45:1] S_out;
    logic        ovf;
    logic        busy;

    int total;
    int bad;

    csa45_accumulator #(.WIDTH(45), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_terms (num_terms),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S_out     (S_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] n, input logic v,
                                 input logic [45:1] d, input logic r);
        start     = s;
        num_terms = n;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0, '0, 1'b0);
        #8;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_S_out", 64'(S_out), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic job: 5 + 7 + 11
        applyStimulus(1'b1, 8'd3, 1'b0, '0, 1'b0);
        tick();
        checkOutput("basic_in_ready", 64'(in_ready), 64'd1);
        checkOutput("basic_busy", 64'(busy), 64'd1);
        applyStimulus(1'b0, 8'd0, 1'b1, 45'd5, 1'b0);
        tick();
        in_data = 45'd7;
        tick();
        checkOutput("basic_no_early_valid", 64'(out_valid), 64'd0);
        checkOutput("basic_partial", 64'(S_out), 64'd12);
        in_data = 45'd11;
        tick();
        in_valid = 1'b0;
        checkOutput("basic_out_valid", 64'(out_valid), 64'd1);
        checkOutput("basic_in_ready_done", 64'(in_ready), 64'd0);
        checkOutput("basic_sum", 64'(S_out), 64'd23);
        checkOutput("basic_ovf", 64'(ovf), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("basic_idle_busy", 64'(busy), 64'd0);
        checkOutput("basic_idle_valid", 64'(out_valid), 64'd0);

        // Overflow: (2^45-1) + 2 wraps to 1
        applyStimulus(1'b1, 8'd2, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 45'h1FFF_FFFF_FFFF, 1'b0);
        tick();
        checkOutput("ovf_first_no_wrap", 64'(ovf), 64'd0);
        in_data = 45'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("ovf_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("ovf_hold_flag", 64'(ovf), 64'd1);
            checkOutput("ovf_hold_sum", 64'(S_out), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("ovf_kept_idle", 64'(ovf), 64'd1);
        checkOutput("ovf_sum_kept_idle", 64'(S_out), 64'd1);

        // Bubbles: four terms of 2^32 with in_valid alternating
        applyStimulus(1'b1, 8'd4, 1'b0, '0, 1'b0);
        tick();
        start = 1'b0;
        checkOutput("bubble_ovf_cleared", 64'(ovf), 64'd0);
        checkOutput("bubble_acc_cleared", 64'(S_out), 64'd0);
        in_data = 45'h1_0000_0000;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            checkOutput("bubble_acc", 64'(S_out), 64'(i / 2 + 1) << 32);
        end
        in_valid = 1'b0;
        checkOutput("bubble_valid", 64'(out_valid), 64'd1);
        checkOutput("bubble_sum", 64'(S_out), 64'h4_0000_0000);
        checkOutput("bubble_ovf", 64'(ovf), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Zero terms: straight to DONE, operand port never ready
        applyStimulus(1'b1, 8'd0, 1'b1, 45'd77, 1'b0);
        checkOutput("zero_in_ready_idle", 64'(in_ready), 64'd0);
        tick();
        start = 1'b0;
        checkOutput("zero_valid", 64'(out_valid), 64'd1);
        checkOutput("zero_in_ready", 64'(in_ready), 64'd0);
        checkOutput("zero_sum", 64'(S_out), 64'd0);
        checkOutput("zero_ovf", 64'(ovf), 64'd0);
        tick();
        checkOutput("zero_sum_held", 64'(S_out), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("zero_idle_busy", 64'(busy), 64'd0);

        // Backpressure with start pulsed in DONE
        applyStimulus(1'b1, 8'd1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 45'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start     = 1'b1;
            num_terms = 8'd5;
            tick();
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_sum", 64'(S_out), 64'd3);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        applyStimulus(1'b0, 8'd0, 1'b0, '0, 1'b0);
        checkOutput("bp_idle_busy", 64'(busy), 64'd0);
        checkOutput("bp_idle_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_idle_in_ready", 64'(in_ready), 64'd0);

        // Reset mid-job after two of four terms
        applyStimulus(1'b1, 8'd4, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 45'd100, 1'b0);
        tick();
        tick();
        checkOutput("rmj_partial", 64'(S_out), 64'd200);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rmj_S_out", 64'(S_out), 64'd0);
        checkOutput("rmj_busy", 64'(busy), 64'd0);
        checkOutput("rmj_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rmj_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rmj_ovf", 64'(ovf), 64'd0);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'd1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'd0, 1'b1, 45'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("rmj_new_valid", 64'(out_valid), 64'd1);
        checkOutput("rmj_new_sum", 64'(S_out), 64'd9);
        checkOutput("rmj_new_ovf", 64'(ovf), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("rmj_final_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
